// File: rtl/clint_unit.sv
`default_nettype none
// ============================================================================
//  Module   : clint_unit
//  Brief    : Core-local interruptor. It has a software interrupt bit, an
//             external interrupt pending latch with an input synchronizer, and
//             a 64-bit mtime/mtimecmp timer. Access is through a simple
//             two-cycle req/ack register bus.
//  Revision : 1.0 - initial release
// ============================================================================
module clint_unit #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    input  logic        ext_irq,
    output logic        machine_software_interrupt,
    output logic        machine_timer_interrupt,
    output logic        machine_external_interrupt
);

    // Word-aligned register addresses
    localparam logic [15:0] C_ADDR_MSIP       = 16'h0000;
    localparam logic [15:0] C_ADDR_EXT_PEND   = 16'h0010;
    localparam logic [15:0] C_ADDR_MTIMECMP_L = 16'h4000;
    localparam logic [15:0] C_ADDR_MTIMECMP_H = 16'h4004;
    localparam logic [15:0] C_ADDR_MTIME_L    = 16'hBFF8;
    localparam logic [15:0] C_ADDR_MTIME_H    = 16'hBFFC;

    // Terminal count of the prescale counter
    localparam logic [15:0] C_PRESCALE_MAX = 16'(PRESCALE - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // Bus FSM and response data
    state_t      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;

    // Architectural registers
    logic        msip_q, msip_d;
    logic        ext_pend_q, ext_pend_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] mtime_q, mtime_d;
    logic [15:0] presc_q, presc_d;
    logic        mti_q, mti_d;

    // External interrupt synchronizer and edge detector
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        edge_q, edge_d;

    // Combinational helpers
    logic [15:0] w_word;
    logic        w_access;
    logic        w_write;
    logic [31:0] w_read_data;
    logic        w_wr_msip;
    logic        w_wr_ext_pend;
    logic        w_wr_cmp_lo;
    logic        w_wr_cmp_hi;
    logic        w_wr_mtime_lo;
    logic        w_wr_mtime_hi;
    logic        w_tick;
    logic        w_ext_rise;
    logic        w_unused_addr;

    // The two low address bits select bytes within a word and play no role
    assign w_unused_addr = ^addr[1:0];
    assign w_word        = {addr[15:2], 2'b00};

    // Bus FSM: IDLE accepts a request, RESP presents ack for exactly one cycle
    always_comb begin
        state_d  = state_q;
        rdata_d  = '0;
        w_access = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d  = ST_RESP;
                    rdata_d  = w_read_data;
                    w_access = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign w_write       = w_access & we;
    assign w_wr_msip     = w_write && (w_word == C_ADDR_MSIP);
    assign w_wr_ext_pend = w_write && (w_word == C_ADDR_EXT_PEND);
    assign w_wr_cmp_lo   = w_write && (w_word == C_ADDR_MTIMECMP_L);
    assign w_wr_cmp_hi   = w_write && (w_word == C_ADDR_MTIMECMP_H);
    assign w_wr_mtime_lo = w_write && (w_word == C_ADDR_MTIME_L);
    assign w_wr_mtime_hi = w_write && (w_word == C_ADDR_MTIME_H);

    // Read mux works on pre-write register values; unmapped words read zero
    always_comb begin
        w_read_data = '0;
        case (w_word)
            C_ADDR_MSIP:       w_read_data = {31'b0, msip_q};
            C_ADDR_EXT_PEND:   w_read_data = {31'b0, ext_pend_q};
            C_ADDR_MTIMECMP_L: w_read_data = mtimecmp_q[31:0];
            C_ADDR_MTIMECMP_H: w_read_data = mtimecmp_q[63:32];
            C_ADDR_MTIME_L:    w_read_data = mtime_q[31:0];
            C_ADDR_MTIME_H:    w_read_data = mtime_q[63:32];
            default:           w_read_data = '0;
        endcase
    end

    assign w_tick = (presc_q == C_PRESCALE_MAX);

    // Timebase: a write to either mtime half overrides the increment and restarts the prescaler
    always_comb begin
        mtime_d = mtime_q;
        presc_d = w_tick ? 16'd0 : presc_q + 16'd1;
        if (w_wr_mtime_lo) begin
            mtime_d[31:0] = wdata;
            presc_d       = 16'd0;
        end else if (w_wr_mtime_hi) begin
            mtime_d[63:32] = wdata;
            presc_d        = 16'd0;
        end else if (w_tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // Compare register halves and the registered timer comparison
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (w_wr_cmp_lo) begin
            mtimecmp_d[31:0] = wdata;
        end
        if (w_wr_cmp_hi) begin
            mtimecmp_d[63:32] = wdata;
        end
        mti_d = (mtime_q >= mtimecmp_q);
    end

    assign w_ext_rise = sync2_q & ~edge_q;

    // Software bit, external synchronizer and pending latch (a new edge beats a clear)
    always_comb begin
        msip_d  = msip_q;
        sync1_d = ext_irq;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        if (w_wr_msip) begin
            msip_d = wdata[0];
        end
        ext_pend_d = ext_pend_q;
        if (w_ext_rise) begin
            ext_pend_d = 1'b1;
        end else if (w_wr_ext_pend && wdata[0]) begin
            ext_pend_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rdata_q    <= '0;
            msip_q     <= 1'b0;
            ext_pend_q <= 1'b0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtime_q    <= '0;
            presc_q    <= '0;
            mti_q      <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            msip_q     <= msip_d;
            ext_pend_q <= ext_pend_d;
            mtimecmp_q <= mtimecmp_d;
            mtime_q    <= mtime_d;
            presc_q    <= presc_d;
            mti_q      <= mti_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            edge_q     <= edge_d;
        end
    end

    assign ack                        = (state_q == ST_RESP);
    assign rdata                      = rdata_q;
    assign machine_software_interrupt = msip_q;
    assign machine_timer_interrupt    = mti_q;
    assign machine_external_interrupt = ext_pend_q;

endmodule
`default_nettype wire

// File: doc/clint_unit.md
CLINT_UNIT -- requirements
Module: clint_unit

Interface
REQ-001 Parameter PRESCALE, default 1, sets the number of clk cycles per mtime increment (legal range 1..65535).
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; asserts immediately and is released synchronously to clk.
REQ-004 req  input  1  bus request, sampled only in IDLE.
REQ-005 we  input  1  write enable qualifying req.
REQ-006 addr  input  16  byte address; addr[1:0] ignored.
REQ-007 wdata  input  32  write data.
REQ-008 rdata  output  32  read data, valid while ack=1, otherwise 0.
REQ-009 ack  output  1  one-cycle response pulse.
REQ-010 ext_irq  input  1  asynchronous external interrupt line.
REQ-011 machine_software_interrupt  output  1  level, equal to MSIP bit 0.
REQ-012 machine_timer_interrupt  output  1  level, registered result of mtime >= mtimecmp.
REQ-013 machine_external_interrupt  output  1  level, equal to the EXT_PEND bit.

Function
REQ-014 Register map (word): 0x0000 MSIP[0]; 0x0010 EXT_PEND[0] (write-1-to-clear); 0x4000 MTIMECMP[31:0]; 0x4004 MTIMECMP[63:32]; 0xBFF8 MTIME[31:0]; 0xBFFC MTIME[63:32].
REQ-015 Unmapped addresses return rdata=0, writes have no effect, and ack still pulses.
REQ-016 Bus FSM states: IDLE and RESP; IDLE with req=1 moves to RESP at the next edge; RESP always returns to IDLE.
REQ-017 ack=1 only in RESP, so each access takes exactly 2 cycles; req is ignored in RESP.
REQ-018 The write takes effect at the IDLE->RESP edge; read data is captured at the same edge from pre-write register values.
REQ-019 A 16-bit prescale counter counts 0..PRESCALE-1 and wraps; mtime increments by 1 (64-bit, carry from bit 31 into bit 32) in the cycle the counter wraps.
REQ-020 mtime wraps from 2^64-1 to 0.
REQ-021 A write to an MTIME half replaces that half only; when it coincides with an increment, the write wins for the written half and the other half keeps its old value (no carry).
REQ-022 A write to an MTIME half clears the prescale counter to 0.
REQ-023 A write to an MTIMECMP half replaces that half only.
REQ-024 machine_timer_interrupt is an unsigned 64-bit compare of the current mtime and mtimecmp, registered with 1-cycle latency; it deasserts 1 cycle after a write that makes mtimecmp > mtime.
REQ-025 ext_irq passes through a 2-flop synchronizer followed by an edge-detect flop; a synchronized rising edge sets EXT_PEND.
REQ-026 A set and a write-1-to-clear of EXT_PEND in the same cycle leave EXT_PEND=1 (set wins).
REQ-027 Worst-case external latency: machine_external_interrupt asserts 3 clk edges after ext_irq rises (setup met).
REQ-028 MSIP write updates only bit 0; reads return {31'b0, MSIP}. EXT_PEND reads the same way.

Reset
REQ-029 While rst=0: FSM=IDLE, ack=0, rdata=0, MSIP=0, EXT_PEND=0, synchronizer and edge flops=0, prescale counter=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, all interrupt outputs=0.
REQ-030 Reset asserted mid-access aborts the access, performs no write, and produces no ack after release.
REQ-031 No timer interrupt occurs after reset until mtimecmp is written.

Verification
REQ-032 PRESCALE=1, write MTIMECMP lo=10 and hi=0 -> machine_timer_interrupt rises on the cycle after mtime reaches 10; writing MTIMECMP lo=0xFFFF_FFFF drops it 1 cycle later.
REQ-033 Write MTIME lo=0xFFFF_FFFF, hi=0 -> next increment yields lo=0, hi=1; read back 0xBFFC -> rdata=1 with ack 2 cycles after req.
REQ-034 Write 0x0000 wdata=0x3 -> machine_software_interrupt=1, read returns 0x1; write 0 -> output 0 at the next edge.
REQ-035 Pulse ext_irq high -> machine_external_interrupt=1 within 3 edges; write 0x0010 wdata=1 -> cleared; second rising edge coinciding with the clear -> stays 1.
REQ-036 PRESCALE=4 -> mtime increments once every 4 cycles; a read of 0x1234 -> rdata=0 with ack; rst pulsed during RESP -> all REQ-029 values and no ack.
